// File: rtl/riscboy_ppu_busarb_pkg.sv
// riscboy_ppu_busarb_pkg: AHB encodings and read-data steering shared by the PPU bus arbiter
package riscboy_ppu_busarb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] SIZE_BYTE     = 2'd0;
   localparam logic [1:0] SIZE_HALF     = 2'd1;
   localparam logic [1:0] SIZE_WORD     = 2'd2;
   // Right-justify and zero-extend the addressed lanes of a 32-bit read beat
   function automatic logic [31:0] steer_rdata(input logic [31:0] d, input logic [1:0] lsb, input logic [1:0] size);
      logic [31:0] b;
      logic [31:0] h;
      b = {24'h0, d[{lsb, 3'b000} +: 8]};
      h = {16'h0, d[{lsb[1], 4'b0000} +: 16]};
      return size == SIZE_BYTE ? b : size == SIZE_HALF ? h : d;
   endfunction
endpackage

// File: rtl/riscboy_ppu_rr_arbiter.sv
// riscboy_ppu_rr_arbiter: one-hot pick of the first unmasked request at or after ptr, wrapping by index
module riscboy_ppu_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int W_PTR = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [W_PTR-1:0] ptr,
   output logic [N_REQ-1:0] gnt
);
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] upper;
   logic [N_REQ-1:0] pick;
   // Prefer eligible bits at or above ptr; fall back to the whole set, then isolate the lowest bit
   always_comb begin
      elig  = req & ~mask;
      upper = elig & ~((N_REQ'(1) << ptr) - N_REQ'(1));
      pick  = |upper ? upper : elig;
      gnt   = pick & (~pick + N_REQ'(1));
   end
endmodule

// File: rtl/riscboy_ppu_busarb.sv
// riscboy_ppu_busarb: round-robin sharing of the PPU AHB-Lite read master among N_REQ fetch units.
// Tracks one address phase and one data phase; narrow reads are returned right-justified.
module riscboy_ppu_busarb
   import riscboy_ppu_busarb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_vld,
   input  logic [N_REQ*W_ADDR-1:0] req_addr,
   input  logic [N_REQ*2-1:0]      req_size,
   output logic [N_REQ-1:0]        req_rdy,
   output logic [W_DATA-1:0]       req_data,
   output logic [W_ADDR-1:0]       ahblm_haddr,
   output logic [1:0]              ahblm_htrans,
   output logic [2:0]              ahblm_hsize,
   output logic                    ahblm_hwrite,
   input  logic                    ahblm_hready,
   input  logic                    ahblm_hresp,
   input  logic [W_DATA-1:0]       ahblm_hrdata
);
   localparam int W_PTR = $clog2(N_REQ);
   logic              aphase_vld;
   logic [W_PTR-1:0]  aphase_owner;
   logic [W_ADDR-1:0] aphase_addr;
   logic [1:0]        aphase_size;
   logic              dphase_vld;
   logic [W_PTR-1:0]  dphase_owner;
   logic [1:0]        dphase_lsb;
   logic [1:0]        dphase_size;
   logic [W_PTR-1:0]  rr_ptr;
   logic [N_REQ-1:0]  mask;
   logic [N_REQ-1:0]  gnt;
   logic [W_PTR-1:0]  gnt_idx;
   logic [W_ADDR-1:0] gnt_addr;
   logic [1:0]        gnt_size;
   logic              load;
   logic              done;
   riscboy_ppu_rr_arbiter #(.N_REQ(N_REQ), .W_PTR(W_PTR)) u_arb (
      .req  (req_vld),
      .mask (mask),
      .ptr  (rr_ptr),
      .gnt  (gnt)
   );
   // Owners of either tracked phase stay masked, which also covers the cycle their rdy pulses
   always_comb begin
      mask     = '0;
      req_rdy  = '0;
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_size = '0;
      load     = !aphase_vld || ahblm_hready;
      done     = dphase_vld && ahblm_hready;
      for (int i = 0; i < N_REQ; i++) begin
         mask[i]    = (aphase_vld && aphase_owner == W_PTR'(i)) || (dphase_vld && dphase_owner == W_PTR'(i));
         req_rdy[i] = done && dphase_owner == W_PTR'(i);
         if (gnt[i]) begin
            gnt_idx  = W_PTR'(i);
            gnt_addr = req_addr[i*W_ADDR +: W_ADDR];
            gnt_size = req_size[i*2 +: 2];
         end
      end
   end
   always_comb begin
      ahblm_htrans = aphase_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
      ahblm_haddr  = aphase_addr;
      ahblm_hsize  = {1'b0, aphase_size};
      ahblm_hwrite = 1'b0;
      req_data     = done && !ahblm_hresp ? steer_rdata(ahblm_hrdata, dphase_lsb, dphase_size) : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aphase_vld   <= 1'b0;
         aphase_owner <= '0;
         aphase_addr  <= '0;
         aphase_size  <= '0;
         dphase_vld   <= 1'b0;
         dphase_owner <= '0;
         dphase_lsb   <= '0;
         dphase_size  <= '0;
         rr_ptr       <= '0;
      end else begin
         if (load) begin
            aphase_vld <= |gnt;
            if (|gnt) begin
               aphase_owner <= gnt_idx;
               aphase_addr  <= gnt_addr;
               aphase_size  <= gnt_size;
               rr_ptr       <= gnt_idx == W_PTR'(N_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
         end
         if (aphase_vld && ahblm_hready) begin
            dphase_vld   <= 1'b1;
            dphase_owner <= aphase_owner;
            dphase_lsb   <= aphase_addr[1:0];
            dphase_size  <= aphase_size;
         end else if (ahblm_hready) begin
            dphase_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_riscboy_ppu_busarb.sv
// tb_riscboy_ppu_busarb: directed and randomized checks of the PPU bus arbiter against a transfer-level model
module tb_riscboy_ppu_busarb;
   localparam int N = 4;
   localparam int NCYC = 3000;
   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0] req_vld;
   logic [N*32-1:0] req_addr;
   logic [N*2-1:0] req_size;
   logic [N-1:0] req_rdy;
   logic [31:0] req_data;
   logic [31:0] haddr;
   logic [1:0] htrans;
   logic [2:0] hsize;
   logic hwrite;
   logic hready;
   logic hresp;
   logic [31:0] hrdata;
   int total = 0;
   int bad = 0;
   logic [N-1:0] pend;
   logic [N-1:0] iss;
   logic [31:0] ra [N];
   int rs [N];
   int born [N];
   logic dp_act;
   logic dp_err;
   logic [31:0] dp_addr;
   int dp_size;
   int dp_wait;
   logic hold;
   logic [31:0] p_addr;
   logic [2:0] p_size;
   logic [1:0] p_trans;
   int id;

   always #5 clk = ~clk;

   riscboy_ppu_busarb #(.N_REQ(N), .W_ADDR(32), .W_DATA(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_vld      (req_vld),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_rdy      (req_rdy),
      .req_data     (req_data),
      .ahblm_haddr  (haddr),
      .ahblm_htrans (htrans),
      .ahblm_hsize  (hsize),
      .ahblm_hwrite (hwrite),
      .ahblm_hready (hready),
      .ahblm_hresp  (hresp),
      .ahblm_hrdata (hrdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      return ((a >> 2) * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Spec rule: shift the word right by the byte offset, keep the transfer width
   function automatic logic [31:0] expect_data(input logic [31:0] w, input logic [31:0] a, input int s);
      logic [31:0] sh;
      sh = w >> (8 * (a % 4));
      return s == 0 ? sh & 32'hFF : s == 1 ? sh & 32'hFFFF : w;
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [1:0] s);
      req_addr[i*32 +: 32] = a;
      req_size[i*2 +: 2] = s;
      req_vld[i] = 1'b1;
   endtask

   task automatic do_reset;
      req_vld = '0;
      hready = 1'b1;
      hresp = 1'b0;
      hrdata = '0;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic single(input int i, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, input logic [31:0] e);
      tick;
      set_req(i, a, s);
      tick;
      #1;
      chk("one_nonseq", htrans, 2'b10);
      chk("one_addr", haddr, a);
      chk("one_size", hsize, {1'b0, s});
      chk("one_rdy_early", req_rdy, 0);
      tick;
      hrdata = d;
      #1;
      chk("one_rdy", req_rdy, 32'd1 << i);
      chk("one_data", req_data, e);
      req_vld[i] = 1'b0;
      hrdata = '0;
      tick;
      #1;
      chk("one_idle", htrans, 2'b00);
      chk("one_no_rdy", req_rdy, 0);
   endtask

   initial begin
      req_addr = '0;
      req_size = '0;
      req_vld = '0;
      hready = 1'b1;
      hresp = 1'b0;
      hrdata = 32'hFFFFFFFF;
      rst_n = 1'b0;
      #2;
      chk("rst_htrans", htrans, 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_hsize", hsize, 0);
      chk("rst_rdy", req_rdy, 0);
      chk("rst_data", req_data, 0);
      do_reset;
      // Single requester latency and narrow steering
      single(0, 32'h100, 2'd2, 32'hCAFEBABE, 32'hCAFEBABE);
      single(0, 32'h203, 2'd0, 32'hAABBCCDD, 32'h000000AA);
      single(0, 32'h202, 2'd1, 32'hAABBCCDD, 32'h0000AABB);
      // All four held high: back-to-back round robin
      do_reset;
      tick;
      for (int i = 0; i < N; i++) set_req(i, 32'h1000 * (i + 1), 2'd2);
      hrdata = 32'hC0FFEE00;
      for (int k = 1; k <= 9; k++) begin
         tick;
         #1;
         chk("rr_trans", htrans, 2'b10);
         chk("rr_addr", haddr, 32'h1000 * ((k - 1) % N + 1));
         chk("rr_rdy", req_rdy, k >= 2 ? 32'd1 << ((k - 2) % N) : 32'd0);
         if (k >= 2) chk("rr_data", req_data, 32'hC0FFEE00);
      end
      req_vld = '0;
      // Wait states during a data phase with an address phase pending
      do_reset;
      tick;
      set_req(0, 32'h400, 2'd2);
      set_req(1, 32'h500, 2'd1);
      tick;
      #1;
      chk("ws_first_addr", haddr, 32'h400);
      for (int k = 0; k < 3; k++) begin
         tick;
         hready = 1'b0;
         hrdata = 32'hDEAD0000;
         #1;
         chk("ws_trans", htrans, 2'b10);
         chk("ws_addr", haddr, 32'h500);
         chk("ws_size", hsize, 3'd1);
         chk("ws_rdy", req_rdy, 0);
      end
      tick;
      hready = 1'b1;
      hrdata = 32'h11223344;
      #1;
      chk("ws_rdy0", req_rdy, 32'h1);
      chk("ws_data0", req_data, 32'h11223344);
      req_vld[0] = 1'b0;
      hrdata = 32'h55667788;
      tick;
      #1;
      chk("ws_rdy1", req_rdy, 32'h2);
      chk("ws_data1", req_data, 32'h00007788);
      chk("ws_idle", htrans, 2'b00);
      req_vld[1] = 1'b0;
      // Two-cycle error response on req1, req2 behind it completes normally
      do_reset;
      tick;
      set_req(1, 32'h600, 2'd2);
      set_req(2, 32'h701, 2'd0);
      tick;
      #1;
      chk("err_addr1", haddr, 32'h600);
      tick;
      hready = 1'b0;
      hresp = 1'b1;
      hrdata = 32'hFFFFFFFF;
      #1;
      chk("err_wait_rdy", req_rdy, 0);
      chk("err_addr2", haddr, 32'h701);
      chk("err_trans2", htrans, 2'b10);
      tick;
      hready = 1'b1;
      #1;
      chk("err_rdy", req_rdy, 32'h2);
      chk("err_data", req_data, 0);
      req_vld[1] = 1'b0;
      hresp = 1'b0;
      hrdata = 32'hA1B2C3D4;
      tick;
      #1;
      chk("err_next_rdy", req_rdy, 32'h4);
      chk("err_next_data", req_data, 32'h000000C3);
      req_vld[2] = 1'b0;
      // Asynchronous reset in the middle of a transfer
      do_reset;
      tick;
      set_req(0, 32'h800, 2'd2);
      set_req(1, 32'h900, 2'd2);
      tick;
      tick;
      hrdata = 32'h12121212;
      #1;
      chk("ar_pre_rdy", req_rdy, 32'h1);
      chk("ar_pre_trans", htrans, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("ar_htrans", htrans, 0);
      chk("ar_haddr", haddr, 0);
      chk("ar_hsize", hsize, 0);
      chk("ar_rdy", req_rdy, 0);
      chk("ar_data", req_data, 0);
      req_vld = '0;
      tick;
      rst_n = 1'b1;
      single(3, 32'hA08, 2'd2, 32'h0BADF00D, 32'h0BADF00D);
      // Randomized traffic against a transfer-level slave and requester model
      do_reset;
      pend = '0;
      iss = '0;
      dp_act = 1'b0;
      dp_err = 1'b0;
      dp_addr = '0;
      dp_size = 0;
      dp_wait = 0;
      hold = 1'b0;
      for (int c = 0; c < NCYC + 100; c++) begin
         tick;
         if (dp_act) begin
            hready = dp_wait == 0;
            hresp = dp_err && dp_wait <= 1;
            hrdata = hready && !hresp ? memw(dp_addr) : $urandom;
         end else begin
            hready = 1'b1;
            hresp = 1'b0;
            hrdata = $urandom;
         end
         for (int i = 0; i < N; i++) begin
            if (c < NCYC && !pend[i] && $urandom_range(0, 3) == 0) begin
               rs[i] = $urandom_range(0, 2);
               ra[i] = $urandom;
               ra[i][15:14] = 2'(i);
               ra[i] = ra[i] & ~((32'd1 << rs[i]) - 32'd1);
               set_req(i, ra[i], 2'(rs[i]));
               pend[i] = 1'b1;
               iss[i] = 1'b0;
               born[i] = c;
            end
         end
         #1;
         chk("hwrite", hwrite, 0);
         chk("htrans_enc", htrans == 2'b00 || htrans == 2'b10, 1);
         if (hold) begin
            chk("hold_addr", haddr, p_addr);
            chk("hold_size", hsize, p_size);
            chk("hold_trans", htrans, p_trans);
         end
         chk("rnd_rdy", req_rdy, dp_act && hready ? 32'd1 << dp_addr[15:14] : 32'd0);
         if (dp_act && hready) begin
            id = dp_addr[15:14];
            chk("rnd_data", req_data, dp_err ? 32'd0 : expect_data(memw(dp_addr), dp_addr, dp_size));
            chk("rnd_latency", c - born[id] <= 48, 1);
            pend[id] = 1'b0;
            iss[id] = 1'b0;
            req_vld[id] = 1'b0;
         end
         if (htrans == 2'b10 && hready) begin
            id = haddr[15:14];
            chk("gnt_owner", {pend[id], iss[id]}, 2'b10);
            chk("gnt_addr", haddr, ra[id]);
            chk("gnt_size", hsize, rs[id]);
            iss[id] = 1'b1;
            dp_act = 1'b1;
            dp_addr = haddr;
            dp_size = hsize[1:0];
            dp_err = $urandom_range(0, 7) == 0;
            dp_wait = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3);
            if (dp_err && dp_wait == 0) dp_wait = 1;
         end else if (hready) begin
            dp_act = 1'b0;
         end else begin
            dp_wait--;
         end
         hold = htrans == 2'b10 && !hready;
         p_addr = haddr;
         p_size = hsize;
         p_trans = htrans;
      end
      chk("drained", pend, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
